flash_bitstream_loader: RTL and testbench



---
 rtl/flash_bitstream_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_flash_bitstream_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_bitstream_loader.sv
// Autonomous FPGA configuration loader: READ (0x03) from SPI NOR flash, optional
// release-power-down frame first, bytes streamed bit-serially into the config chain.
module flash_bitstream_loader #(
    parameter int          BITSTREAM_BYTES = 1024,
    parameter logic [23:0] START_ADDR      = 24'h000000,
    parameter int          SCLK_DIV        = 1,
    parameter int          WAKEUP          = 1,
    parameter int          CS_GAP          = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic spi_sclk_o,
    output logic spi_cs_no,
    output logic spi_mosi_o,
    input  logic spi_miso_i,
    output logic cfg_data_o,
    output logic cfg_shift_o,
    output logic cfg_latch_o
);

    localparam int BYTE_W = $clog2(BITSTREAM_BYTES + 1);
    // ADDR needs to count three bytes even when the bitstream is a single byte
    localparam int CNT_W  = (BYTE_W < 2) ? 2 : BYTE_W;
    localparam int PH_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(BITSTREAM_BYTES - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(2);
    localparam logic [23:0]      FRAME_WAKE = 24'hAB0000;
    localparam logic [23:0]      FRAME_READ = 24'h030000;

    typedef enum logic [2:0] {
        S_IDLE, S_WAKE, S_GAP, S_CMD, S_ADDR, S_DATA, S_LATCH, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PH_W-1:0]    r_ph, w_ph_nxt;
    logic               r_hi, w_hi_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [CNT_W-1:0]   r_byte, w_byte_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [23:0]        r_tx, w_tx_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               r_csn, w_csn_nxt;
    logic               r_mosi, w_mosi_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_cfg_data, w_cfg_data_nxt;
    logic               r_cfg_shift, w_cfg_shift_nxt;
    logic               r_cfg_last, w_cfg_last_nxt;
    logic               r_cfg_latch, w_cfg_latch_nxt;
    logic               r_latched, w_latched_nxt;

    logic w_in_frame;
    logic w_seg_last;
    logic w_seg_end;
    logic w_sample;

    assign w_in_frame = (r_state == S_WAKE) || (r_state == S_CMD) ||
                        (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_seg_last = (r_state == S_ADDR) ? (r_byte == ADDR_LAST) :
                        (r_state == S_DATA) ? (r_byte == DATA_LAST) : 1'b1;
    assign w_seg_end  = r_hi && (r_ph == PH_LAST) && (r_bit == 3'd7) && w_seg_last;
    // MISO is captured at the edge that closes the first SCLK-high cycle
    assign w_sample   = (r_state == S_DATA) && r_hi && (r_ph == '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_ph_nxt        = r_ph;
        w_hi_nxt        = r_hi;
        w_bit_nxt       = r_bit;
        w_byte_nxt      = r_byte;
        w_gap_nxt       = r_gap;
        w_tx_nxt        = r_tx;
        w_sclk_nxt      = r_sclk;
        w_csn_nxt       = r_csn;
        w_mosi_nxt      = r_mosi;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_cfg_shift_nxt = w_sample;
        w_cfg_data_nxt  = w_sample ? spi_miso_i : r_cfg_data;
        w_cfg_last_nxt  = w_sample ? ((r_bit == 3'd7) && (r_byte == DATA_LAST)) : r_cfg_last;
        w_cfg_latch_nxt = r_cfg_shift && r_cfg_last;
        w_latched_nxt   = r_latched || r_cfg_latch;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_csn_nxt     = 1'b0;
                    w_sclk_nxt    = 1'b0;
                    w_ph_nxt      = '0;
                    w_hi_nxt      = 1'b0;
                    w_bit_nxt     = 3'd0;
                    w_byte_nxt    = '0;
                    w_latched_nxt = 1'b0;
                    if (WAKEUP != 0) begin
                        w_state_nxt = S_WAKE;
                        w_mosi_nxt  = FRAME_WAKE[23];
                        w_tx_nxt    = {FRAME_WAKE[22:0], 1'b0};
                    end else begin
                        w_state_nxt = S_CMD;
                        w_mosi_nxt  = FRAME_READ[23];
                        w_tx_nxt    = {FRAME_READ[22:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_CMD;
                    w_csn_nxt   = 1'b0;
                    w_mosi_nxt  = FRAME_READ[23];
                    w_tx_nxt    = {FRAME_READ[22:0], 1'b0};
                    w_ph_nxt    = '0;
                    w_hi_nxt    = 1'b0;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = '0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_cfg_latch) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: ;
        endcase

        if (w_in_frame) begin
            if (!r_hi) begin
                if (r_ph == PH_LAST) begin
                    w_ph_nxt   = '0;
                    w_hi_nxt   = 1'b1;
                    w_sclk_nxt = 1'b1;
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end else if (r_ph != PH_LAST) begin
                w_ph_nxt = r_ph + 1'b1;
            end else begin
                w_ph_nxt   = '0;
                w_hi_nxt   = 1'b0;
                w_sclk_nxt = 1'b0;
                w_bit_nxt  = r_bit + 3'd1;
                if (r_bit == 3'd7) begin
                    w_byte_nxt = r_byte + 1'b1;
                end
                w_mosi_nxt = (r_state == S_DATA) ? 1'b0 : r_tx[23];
                w_tx_nxt   = {r_tx[22:0], 1'b0};
                if (w_seg_end) begin
                    w_bit_nxt  = 3'd0;
                    w_byte_nxt = '0;
                    case (r_state)
                        S_WAKE: begin
                            w_state_nxt = S_GAP;
                            w_csn_nxt   = 1'b1;
                            w_mosi_nxt  = 1'b0;
                            w_gap_nxt   = '0;
                        end
                        S_CMD: begin
                            w_state_nxt = S_ADDR;
                            w_mosi_nxt  = START_ADDR[23];
                            w_tx_nxt    = {START_ADDR[22:0], 1'b0};
                        end
                        S_ADDR: begin
                            w_state_nxt = S_DATA;
                            w_mosi_nxt  = 1'b0;
                        end
                        default: begin
                            w_csn_nxt  = 1'b1;
                            w_mosi_nxt = 1'b0;
                            // with slow SCLK the latch strobe can already be out before CS rises
                            if (r_cfg_latch || r_latched) begin
                                w_state_nxt = S_DONE;
                                w_busy_nxt  = 1'b0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_LATCH;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ph        <= '0;
            r_hi        <= 1'b0;
            r_bit       <= 3'd0;
            r_byte      <= '0;
            r_gap       <= '0;
            r_tx        <= '0;
            r_sclk      <= 1'b0;
            r_csn       <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_data  <= 1'b0;
            r_cfg_shift <= 1'b0;
            r_cfg_last  <= 1'b0;
            r_cfg_latch <= 1'b0;
            r_latched   <= 1'b0;
        end else begin
            r_ph        <= w_ph_nxt;
            r_hi        <= w_hi_nxt;
            r_bit       <= w_bit_nxt;
            r_byte      <= w_byte_nxt;
            r_gap       <= w_gap_nxt;
            r_tx        <= w_tx_nxt;
            r_sclk      <= w_sclk_nxt;
            r_csn       <= w_csn_nxt;
            r_mosi      <= w_mosi_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cfg_data  <= w_cfg_data_nxt;
            r_cfg_shift <= w_cfg_shift_nxt;
            r_cfg_last  <= w_cfg_last_nxt;
            r_cfg_latch <= w_cfg_latch_nxt;
            r_latched   <= w_latched_nxt;
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign spi_sclk_o  = r_sclk;
    assign spi_cs_no   = r_csn;
    assign spi_mosi_o  = r_mosi;
    assign cfg_data_o  = r_cfg_data;
    assign cfg_shift_o = r_cfg_shift;
    assign cfg_latch_o = r_cfg_latch;

endmodule

// File: tb/tb_flash_bitstream_loader.sv
// Bench for flash_bitstream_loader: four differently parameterised loaders, each
// attached to a behavioural SPI flash that shifts data out on SCLK falling edges.
module tb_flash_bitstream_loader;

    logic       clk;
    logic [3:0] rstn, start, clr;
    logic [3:0] busy, done, sclk, csn, mosi, miso, cdat, cshift, clatch;

    function automatic int p_n(int g);
        case (g)
            0: return 4;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [23:0] p_addr(int g);
        case (g)
            1: return 24'h123456;
            3: return 24'h000010;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic int p_div(int g);
        return (g == 3) ? 3 : 1;
    endfunction

    function automatic int p_wake(int g);
        return (g == 2) ? 1 : 0;
    endfunction

    function automatic logic [7:0] flash_byte(int g, logic [23:0] a);
        case ({8'(g), a})
            32'h00_000000: return 8'hA5;
            32'h00_000001: return 8'h3C;
            32'h00_000002: return 8'hFF;
            32'h00_000003: return 8'h00;
            32'h01_123456: return 8'h5A;
            32'h02_000000: return 8'hC3;
            32'h02_000001: return 8'h96;
            32'h03_000010: return 8'h81;
            32'h03_000011: return 8'h7E;
            default:       return 8'hEE;
        endcase
    endfunction

    function automatic logic data_bit(int g, logic [23:0] a, int idx);
        logic [7:0] b;
        b = flash_byte(g, a + 24'(idx / 8));
        return b[7 - (idx % 8)];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        flash_bitstream_loader #(
            .BITSTREAM_BYTES(p_n(g)),
            .START_ADDR     (p_addr(g)),
            .SCLK_DIV       (p_div(g)),
            .WAKEUP         (p_wake(g)),
            .CS_GAP         (4)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rstn[g]),
            .start_i    (start[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .spi_sclk_o (sclk[g]),
            .spi_cs_no  (csn[g]),
            .spi_mosi_o (mosi[g]),
            .spi_miso_i (miso[g]),
            .cfg_data_o (cdat[g]),
            .cfg_shift_o(cshift[g]),
            .cfg_latch_o(clatch[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flash model plus observers, all sampled mid-cycle
    logic [3:0]  psclk, pcsn;
    logic [31:0] hdr[4], lasthdr[4], firsthdr[4], stream[4];
    int          cnt[4], nshift[4], nlatch[4], cur[4], lastlow[4], firstlow[4], frames[4], gap[4];

    initial begin
        psclk = '0;
        pcsn  = '1;
        miso  = '0;
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            psclk[g] <= sclk[g];
            pcsn[g]  <= csn[g];
            if (clr[g]) begin
                hdr[g] <= '0; lasthdr[g] <= '0; firsthdr[g] <= '0; stream[g] <= '0;
                cnt[g] <= 0; nshift[g] <= 0; nlatch[g] <= 0; cur[g] <= 0;
                lastlow[g] <= 0; firstlow[g] <= 0; frames[g] <= 0; gap[g] <= 0;
            end else begin
                if (cshift[g]) begin
                    stream[g] <= {stream[g][30:0], cdat[g]};
                    nshift[g] <= nshift[g] + 1;
                end
                if (clatch[g]) nlatch[g] <= nlatch[g] + 1;
                if (!csn[g]) cur[g] <= cur[g] + 1;
                if (!pcsn[g] && csn[g]) begin
                    lastlow[g] <= cur[g];
                    lasthdr[g] <= hdr[g];
                    if (frames[g] == 0) begin
                        firstlow[g] <= cur[g];
                        firsthdr[g] <= hdr[g];
                    end
                    frames[g] <= frames[g] + 1;
                    cur[g]    <= 0;
                end
                if (pcsn[g] && !csn[g]) begin
                    cnt[g] <= 0;
                    hdr[g] <= '0;
                end else if (!csn[g] && !psclk[g] && sclk[g]) begin
                    if (cnt[g] < 32) hdr[g] <= {hdr[g][30:0], mosi[g]};
                    cnt[g] <= cnt[g] + 1;
                end else if (!csn[g] && psclk[g] && !sclk[g] && cnt[g] >= 32) begin
                    miso[g] <= data_bit(g, hdr[g][23:0], cnt[g] - 32);
                end
                if (csn[g] && busy[g] && ((frames[g] == 1 && pcsn[g]) || (frames[g] == 0 && !pcsn[g])))
                    gap[g] <= gap[g] + 1;
            end
        end
    end

    typedef struct {
        int          inst;
        logic [31:0] hdr;
        logic [31:0] stream;
        int          nbits;
        int          cslow;
    } vec_t;

    vec_t vecs[4];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int g);
        clr[g] = 1'b1;
        @(negedge clk);
        #1 clr[g] = 1'b0;
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
        chk($sformatf("start_state_%0d", g), 32'({busy[g], done[g], csn[g], sclk[g], mosi[g]}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, (p_wake(g) != 0)}));
    endtask

    task automatic wait_done(input int g, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done[g]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL timeout_%0d: done_o still 0 after %0d cycles", g, budget);
        end
    endtask

    task automatic wait_shifts(input int g, input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (nshift[g] >= n) break;
        end
    endtask

    task automatic check_result(input vec_t v);
        int g;
        g = v.inst;
        @(posedge clk);
        #1;
        chk($sformatf("read_hdr_%0d", g), lasthdr[g], v.hdr);
        chk($sformatf("cfg_stream_%0d", g), stream[g], v.stream);
        chk($sformatf("shift_count_%0d", g), 32'(nshift[g]), 32'(v.nbits));
        chk($sformatf("latch_count_%0d", g), 32'(nlatch[g]), 32'd1);
        chk($sformatf("cs_low_cycles_%0d", g), 32'(lastlow[g]), 32'(v.cslow));
        chk($sformatf("end_state_%0d", g), 32'({busy[g], done[g], csn[g], sclk[g]}), 32'b0110);
        if (p_wake(g) != 0) begin
            chk("wake_hdr", firsthdr[g], 32'h000000AB);
            chk("wake_frame_cycles", 32'(firstlow[g]), 32'd16);
            chk("cs_gap_cycles", 32'(gap[g]), 32'd4);
        end
    endtask

    task automatic run_load(input vec_t v);
        clear_mon(v.inst);
        pulse_start(v.inst);
        wait_done(v.inst, 3000);
        check_result(v);
    endtask

    initial begin
        vecs[0] = '{0, 32'h03000000, 32'hA53CFF00, 32, 128};
        vecs[1] = '{1, 32'h03123456, 32'h0000005A,  8,  80};
        vecs[2] = '{2, 32'h03000000, 32'h0000C396, 16,  96};
        vecs[3] = '{3, 32'h03000010, 32'h0000817E, 16, 288};

        rstn  = '0;
        start = '0;
        clr   = '1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            chk($sformatf("reset_out_%0d", g),
                32'({busy[g], done[g], sclk[g], csn[g], mosi[g], cdat[g], cshift[g], clatch[g]}),
                32'b00010000);
        rstn = '1;
        clr  = '0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        // start pulsed mid-DATA must not disturb the running load
        clear_mon(0);
        pulse_start(0);
        wait_shifts(0, 10);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 3000);
        check_result(vecs[0]);

        // restart from the sticky-done idle state reproduces the same load
        chk("done_before_restart", 32'(done[0]), 32'd1);
        run_load(vecs[0]);

        // start in the DONE cycle is dropped
        clear_mon(0);
        pulse_start(0);
        wait_done(0, 3000);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", 32'({busy[0], done[0], csn[0]}), 32'b011);

        // asynchronous reset during the second data byte
        clear_mon(0);
        pulse_start(0);
        wait_shifts(0, 12);
        rstn[0] = 1'b0;
        #1;
        chk("abort_outputs", 32'({csn[0], sclk[0], busy[0], done[0], clatch[0]}), 32'b10000);
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_latch", 32'(nlatch[0]), 32'd0);
        run_load(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1);
    end

endmodule
